// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, counter width and behavioural divide helpers.
package mult_div_unit_pkg;

    // Op encodings; the decoder that drives op/start uses these same values.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NONE  = 3'd6
    } md_op_e;

    // IDLE when the latency counter is zero, RUN otherwise.
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int MD_CNT_W       = 4;
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    // Signed divide, returns {remainder, quotient}. The quotient truncates
    // toward zero and the remainder takes the dividend's sign. The
    // 0x80000000 / -1 overflow yields quotient 0x80000000, remainder 0.
    // A zero divisor is replaced by 1 so no X is produced; the caller
    // discards that result.
    function automatic logic [63:0] md_div_s(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = (b == 32'd0) ? 32'sd1 : b;
        if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
            q = 32'sh8000_0000;
            r = 32'sd0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    // Unsigned divide, returns {remainder, quotient}; zero divisor guarded.
    function automatic logic [63:0] md_div_u(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ub;
        ub = (b == 32'd0) ? 32'd1 : b;
        return {a % ub, a / ub};
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage request/response bundle between the pipeline and the mult/div unit.
interface mult_div_unit_if;
    import mult_div_unit_pkg::*;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: holds architectural HI/LO, executes mult/div over a
// fixed latency modelled by a down-counter, and applies mthi/mtlo at once.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic           clk,
    input  logic           reset,
    mult_div_unit_if.slave md
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    logic [MD_CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]         hi_q,      hi_d;
    logic [31:0]         lo_q,      lo_d;
    logic [31:0]         pend_hi_q, pend_hi_d;
    logic [31:0]         pend_lo_q, pend_lo_d;
    logic                pend_dz_q, pend_dz_d;

    md_state_e           state_s;
    logic                go_s;
    logic [63:0]         mul_s_s;
    logic [63:0]         mul_u_s;
    logic [63:0]         div_s_s;
    logic [63:0]         div_u_s;

    assign state_s = (cnt_q != {MD_CNT_W{1'b0}}) ? MD_RUN : MD_IDLE;
    assign go_s    = md.start & ~md.flush;

    // Behavioural 64-bit results for every arithmetic op, picked at the start edge.
    always_comb begin
        mul_s_s = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
        mul_u_s = {32'd0, md.a} * {32'd0, md.b};
        div_s_s = md_div_s(md.a, md.b);
        div_u_s = md_div_u(md.a, md.b);
    end

    // Next-state logic: count down and commit in RUN, accept new work in IDLE.
    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        case (state_s)
            MD_RUN: begin
                // Already past the commit point: flush and start do not interfere.
                cnt_d = cnt_q - {{(MD_CNT_W-1){1'b0}}, 1'b1};
                if ((cnt_q == {{(MD_CNT_W-1){1'b0}}, 1'b1}) && !pend_dz_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end else begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end
            end
            MD_IDLE: begin
                if (go_s) begin
                    case (md.op)
                        MD_MULT: begin
                            {pend_hi_d, pend_lo_d} = mul_s_s;
                            pend_dz_d = 1'b0;
                            cnt_d     = MULT_LOAD;
                        end
                        MD_MULTU: begin
                            {pend_hi_d, pend_lo_d} = mul_u_s;
                            pend_dz_d = 1'b0;
                            cnt_d     = MULT_LOAD;
                        end
                        MD_DIV: begin
                            {pend_hi_d, pend_lo_d} = div_s_s;
                            pend_dz_d = (md.b == 32'd0);
                            cnt_d     = DIV_LOAD;
                        end
                        MD_DIVU: begin
                            {pend_hi_d, pend_lo_d} = div_u_s;
                            pend_dz_d = (md.b == 32'd0);
                            cnt_d     = DIV_LOAD;
                        end
                        MD_MTHI: begin
                            hi_d = md.a;
                        end
                        MD_MTLO: begin
                            lo_d = md.a;
                        end
                        default: begin
                            cnt_d = cnt_q;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = {MD_CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; reset clears HI/LO and drops any pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= {MD_CNT_W{1'b0}};
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    // busy must rise in the start cycle itself so the stall unit sees it in time.
    assign md.busy = (go_s & (md.op <= 3'd3)) | (state_s == MD_RUN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic clk;
    logic reset;
    int   chk_cnt;
    int   pass_cnt;
    int   fail_cnt;
    int   n;

    mult_div_unit_if md();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .md    (md.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, then count busy cycles starting with the start cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_busy,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cyc;
        @(negedge clk);
        md.start = 1'b1; md.op = op; md.a = a; md.b = b; md.flush = 1'b0;
        #1;
        cyc = 0;
        while (md.busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(posedge clk); #1;
            md.start = 1'b0;
            #1;
        end
        check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_busy));
        check({tag, "_hi"}, {32'd0, md.hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, md.lo}, {32'd0, exp_lo});
    endtask

    initial begin
        chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;
        reset = 1'b0;
        md.start = 1'b0; md.op = 3'd0; md.a = 32'd0; md.b = 32'd0; md.flush = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, md.busy}, 64'd0);
        check("reset_hi", {32'd0, md.hi}, 64'd0);
        check("reset_lo", {32'd0, md.lo}, 64'd0);
        reset = 1'b1;

        run_op("mult",  3'd0, 32'hFFFF_FFFF, 32'd2, 6,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 6,  32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 11, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu",  3'd3, 32'hFFFF_FFF9, 32'd2, 11, 32'h0000_0001, 32'h7FFF_FFFC);

        // mthi: no busy, visible next cycle, LO untouched
        @(negedge clk);
        md.start = 1'b1; md.op = 3'd4; md.a = 32'h1234_5678;
        #1;
        check("mthi_busy", {63'd0, md.busy}, 64'd0);
        @(posedge clk); #1;
        md.start = 1'b0;
        #1;
        check("mthi_hi", {32'd0, md.hi}, {32'd0, 32'h1234_5678});
        check("mthi_lo", {32'd0, md.lo}, {32'd0, 32'h7FFF_FFFC});
        check("mthi_busy_after", {63'd0, md.busy}, 64'd0);

        // mtlo
        @(negedge clk);
        md.start = 1'b1; md.op = 3'd5; md.a = 32'hCAFE_F00D;
        #1;
        check("mtlo_busy", {63'd0, md.busy}, 64'd0);
        @(posedge clk); #1;
        md.start = 1'b0;
        #1;
        check("mtlo_lo", {32'd0, md.lo}, {32'd0, 32'hCAFE_F00D});
        check("mtlo_hi", {32'd0, md.hi}, {32'd0, 32'h1234_5678});

        // start together with flush: nothing accepted
        @(negedge clk);
        md.start = 1'b1; md.op = 3'd0; md.a = 32'd5; md.b = 32'd5; md.flush = 1'b1;
        #1;
        check("flush_busy", {63'd0, md.busy}, 64'd0);
        @(posedge clk); #1;
        md.start = 1'b0; md.flush = 1'b0;
        #1;
        check("flush_busy_after", {63'd0, md.busy}, 64'd0);
        repeat (7) @(posedge clk);
        #1;
        check("flush_hi", {32'd0, md.hi}, {32'd0, 32'h1234_5678});
        check("flush_lo", {32'd0, md.lo}, {32'd0, 32'hCAFE_F00D});

        // start while busy is ignored: mult 3*4, then a div attempted mid-run
        @(negedge clk);
        md.start = 1'b1; md.op = 3'd0; md.a = 32'd3; md.b = 32'd4;
        @(posedge clk); #1;
        md.start = 1'b0;
        @(negedge clk);
        md.start = 1'b1; md.op = 3'd2; md.a = 32'd100; md.b = 32'd7;
        #1;
        check("ignored_busy", {63'd0, md.busy}, 64'd1);
        n = 2;
        @(posedge clk); #1;
        md.start = 1'b0;
        #1;
        while (md.busy === 1'b1 && n < 40) begin
            n++;
            @(posedge clk); #2;
        end
        check("ignored_busy_cycles", 64'(n), 64'd6);
        check("ignored_hi", {32'd0, md.hi}, 64'd0);
        check("ignored_lo", {32'd0, md.lo}, 64'd12);

        // divide by zero: full latency, HI/LO unchanged
        run_op("divzero",  3'd2, 32'd7, 32'd0, 11, 32'd0, 32'd12);
        run_op("divuzero", 3'd3, 32'd7, 32'd0, 11, 32'd0, 32'd12);
        // signed overflow case
        run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 11, 32'd0, 32'h8000_0000);

        // reset in cycle t+2 of a mult
        @(negedge clk);
        md.start = 1'b1; md.op = 3'd0; md.a = 32'hFFFF_FFFF; md.b = 32'd2;
        @(posedge clk); #1;
        md.start = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_busy", {63'd0, md.busy}, 64'd1);
        reset = 1'b0;
        #1;
        check("midrst_busy", {63'd0, md.busy}, 64'd0);
        check("midrst_hi", {32'd0, md.hi}, 64'd0);
        check("midrst_lo", {32'd0, md.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("postrst_busy", {63'd0, md.busy}, 64'd0);
        check("postrst_hi", {32'd0, md.hi}, 64'd0);
        check("postrst_lo", {32'd0, md.lo}, 64'd0);

        // back to work after reset
        run_op("mult_after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 6, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit of the pipelined MIPS core, living in the E stage alongside the ALU. It executes mult/multu/div/divu over a fixed multi-cycle latency and handles mthi/mtlo writes. It holds the architectural HI/LO registers read by mfhi/mflo. Its `busy` output feeds the stall unit, which holds any md/mt/mf instruction in D while an operation is in flight.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after the start cycle for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles after the start cycle for div/divu.
- `clk  in  1`: the single clock; all state changes on the rising edge.
- `reset  in  1`: asynchronous, active-low; HI/LO, counter and pending result cleared immediately.
- `start  in  1`: the E-stage instruction is an md/mt instruction this cycle.
- `op  in  3`: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 are no-ops.
- `a  in  32`: forwarded rs value.
- `b  in  32`: forwarded rt value.
- `flush  in  1`: an exception or interrupt is being taken this cycle; the E-stage start is cancelled.
- `busy  out  1`: an operation is in flight, or one is being started this cycle.
- `hi  out  32`: the architectural HI register.
- `lo  out  32`: the architectural LO register.

## Operation
- States: IDLE (`cnt==0`) and RUN (`cnt!=0`). `cnt` is 4 bits; both parameters must be ≤15.
- Accepted start: `start & !flush & cnt==0`. Any other start is ignored, with no state change.
- Accepted mult/multu/div/divu:
  - Compute the 64-bit result from `a`/`b` at the start edge and store it in `pend_hi`/`pend_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
- mult: signed 32×32→64; {hi,lo} = product. multu: the same, unsigned.
- div: signed; lo = quotient truncated toward zero, hi = remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero still runs DIV_CYCLES; HI/LO are left unchanged at commit.
- Accepted mthi/mtlo: write `a` to HI/LO at that edge. No busy cycle; `cnt` is not touched.
- In RUN, `cnt` decrements every edge. On the edge where `cnt==1`, commit pend_hi/pend_lo to HI/LO (div-by-zero excepted) and return to IDLE.
- `busy = (start & !flush & op<=3) | (cnt!=0)`. This is combinational; `start` with op 4/5 does not raise busy.
- `flush` does not abort an operation already in RUN; it has passed the commit point.
- Reset mid-RUN discards the pending result, and HI/LO go to 0.
- `hi`/`lo` are driven straight from registers. mfhi/mflo read them in E and never see pending values, because the stall unit blocks mf while busy.

## Timing
- Reset values: hi=0, lo=0, busy=0, cnt=0.
- Start accepted in cycle t, with N = MULT_CYCLES or DIV_CYCLES:
  - busy is high in cycles t … t+N, i.e. N+1 cycles.
  - HI/LO update at the edge ending cycle t+N.
  - busy is low from cycle t+1+N, and new HI/LO are visible from that cycle.
- mthi/mtlo in cycle t: the new value is visible on `hi`/`lo` in cycle t+1.
- Back-to-back: a new start is accepted in the first cycle with `cnt==0`. There are no dead cycles beyond that.
- `flush` and `start` together in the same cycle: nothing is accepted and busy stays low (if IDLE).

## Structure
- The shared package holds:
  - the op encodings `MD_MULT`…`MD_MTLO`, `MD_NONE`;
  - default latencies `MD_MULT_CYCLES`, `MD_DIV_CYCLES`;
  - the 4-bit counter width constant.
- The decoder that produces `op` and `start` uses the same package constants.
- Single module; no sub-module is needed. The arithmetic is behavioural, and the fixed latency is modelled by the counter.

## Test plan
- **mult.** a=0xFFFFFFFF, b=2, start=1 for one cycle.
  - busy high for 6 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- **multu.** Same operands → hi=0x00000001, lo=0xFFFFFFFE.
- **div.** a=0xFFFFFFF9 (−7), b=2.
  - busy high for 11 cycles.
  - Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- **divu.** Same operands → lo=0x7FFFFFFC, hi=0x00000001.
- **mthi, flush and start-while-busy.**
  - mthi a=0x12345678 → next cycle hi=0x12345678, busy never high.
  - start mult with flush=1 → busy low, HI/LO unchanged.
  - A start while cnt!=0 is ignored.
- **Div-by-zero and reset mid-operation.**
  - div with b=0 → 11 busy cycles, HI/LO unchanged.
  - Start mult, assert reset at cycle t+2 → busy, hi, lo all 0 immediately.
  - After reset release, no late commit occurs.
